// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI write-path types, response codes and widths
package axi_pkg;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = 4;
    localparam int LEN_W  = 4;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_RESP = 2'b10
    } wr_state_e;

    // Severity order DECERR > SLVERR > OKAY falls out of the encodings as a bitwise OR.
    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        return a | b;
    endfunction
endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - combinational next beat address for FIXED/INCR/WRAP bursts
// Ports: i_addr current beat byte address, i_size log2 bytes per beat, i_len beats minus one,
//        i_burst burst type, o_next_addr byte address of the following beat.
module axi_burst_addr_gen
    import axi_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_size,
    input  logic [LEN_W-1:0]  i_len,
    input  burst_e            i_burst,
    output logic [ADDR_W-1:0] o_next_addr
);
    logic [ADDR_W-1:0] w_bytes;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_wrap_mask;

    assign w_bytes     = ADDR_W'(1) << i_size;
    assign w_incr      = i_addr + w_bytes;
    // Wrap window is bytes*(len+1); only meaningful when len+1 is a power of two.
    assign w_wrap_mask = (w_bytes * (ADDR_W'(i_len) + ADDR_W'(1))) - ADDR_W'(1);

    always_comb begin
        o_next_addr = i_addr;
        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_INCR:  o_next_addr = w_incr;
            BURST_WRAP:  o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
            default:     o_next_addr = i_addr;
        endcase
    end
endmodule

// File: rtl/axi_wr_slave.sv
// rtl/axi_wr_slave.sv - AXI write slave turning one burst at a time into single-beat memory writes
// Ports: aclk/arst clock and sync active-low reset; aw* write address channel; w* write data
//        channel; b* write response channel; mem_* registered word-addressed memory write port.
module axi_wr_slave
    import axi_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_BASE = 32'h0000_0000,
    parameter int                MEM_AW    = 10
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [LEN_W-1:0]  awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   wid,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wmask
);
    localparam logic [ADDR_W:0] MEM_BYTES = 33'd8 << MEM_AW;

    function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] off;
        off = {1'b0, a} - {1'b0, ADDR_BASE};
        return (a >= ADDR_BASE) && (off < MEM_BYTES);
    endfunction

    wr_state_e         r_state;
    wr_state_e         w_next_state;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [2:0]        r_size;
    burst_e            r_burst;
    logic [LEN_W-1:0]  r_cnt;
    logic [1:0]        r_err;
    // Set when no further beat of this burst may reach memory (capture error or range overflow).
    logic              r_sup;
    logic              r_mem_we;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [STRB_W-1:0] r_mem_wmask;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_b_hs;
    logic              w_last_beat;
    logic              w_aw_decerr;
    logic              w_aw_slverr;
    logic [1:0]        w_aw_err;
    logic              w_id_ok;
    logic              w_beat_in_range;
    logic              w_range_err;
    logic              w_do_write;
    logic [1:0]        w_beat_err;
    logic [ADDR_W-1:0] w_next_addr;

    axi_burst_addr_gen u_addr_gen (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr)
    );

    assign w_aw_hs     = awvalid && awready;
    assign w_w_hs      = wvalid && wready;
    assign w_b_hs      = bvalid && bready;
    assign w_last_beat = (r_cnt == r_len);

    assign w_aw_decerr = !f_in_range(awaddr);
    assign w_aw_slverr = (awsize > 3'd3) || (awburst == BURST_RSVD) ||
                         ((awburst == BURST_WRAP) &&
                          !((awlen == 4'd1) || (awlen == 4'd3) || (awlen == 4'd7) || (awlen == 4'd15)));
    assign w_aw_err    = w_aw_decerr ? RESP_DECERR : (w_aw_slverr ? RESP_SLVERR : RESP_OKAY);

    assign w_id_ok         = (wid == r_id);
    assign w_beat_in_range = f_in_range(r_addr);
    // Only the first beat to leave the window is an overflow; afterwards the burst is already muted.
    assign w_range_err     = !r_sup && !w_beat_in_range;
    assign w_do_write      = w_w_hs && !r_sup && w_beat_in_range && w_id_ok;
    assign w_beat_err      = resp_merge(w_range_err ? RESP_DECERR : RESP_OKAY,
                                        (!w_id_ok || (wlast != w_last_beat)) ? RESP_SLVERR : RESP_OKAY);

    always_ff @(posedge aclk) begin
        if (!arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_aw_hs) w_next_state = ST_DATA;
            ST_DATA: if (w_w_hs && w_last_beat) w_next_state = ST_RESP;
            ST_RESP: if (w_b_hs) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (r_state)
            ST_IDLE: awready = arst;
            ST_DATA: wready  = 1'b1;
            ST_RESP: bvalid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arst) begin
            r_id        <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= BURST_FIXED;
            r_cnt       <= '0;
            r_err       <= RESP_OKAY;
            r_sup       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
        end else begin
            r_mem_we <= w_do_write;
            if (w_do_write) begin
                r_mem_addr  <= MEM_AW'((r_addr - ADDR_BASE) >> 3);
                r_mem_wdata <= wdata;
                r_mem_wmask <= wstrb;
            end
            if (w_aw_hs) begin
                r_id    <= awid;
                r_addr  <= awaddr;
                r_len   <= awlen;
                r_size  <= awsize;
                r_burst <= burst_e'(awburst);
                r_cnt   <= '0;
                r_err   <= w_aw_err;
                r_sup   <= w_aw_decerr || w_aw_slverr;
            end
            if (w_w_hs) begin
                r_addr <= w_next_addr;
                r_cnt  <= r_cnt + 1'b1;
                r_err  <= resp_merge(r_err, w_beat_err);
                r_sup  <= r_sup | w_range_err;
            end
        end
    end

    assign bid       = r_id;
    assign bresp     = r_err;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wmask = r_mem_wmask;
endmodule

// File: tb/tb_axi_wr_slave.sv
// tb/tb_axi_wr_slave.sv - self-checking bench for axi_wr_slave with a burst-level reference model
module tb_axi_wr_slave;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int          MAW  = 10;

    logic        aclk = 1'b0;
    logic        arst;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [63:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic [3:0]  mem_wmask;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] beat_data [16];
    logic [3:0]  beat_strb [16];
    logic        obs_we    [16];
    logic [9:0]  obs_addr  [16];
    logic [63:0] obs_data  [16];
    logic [3:0]  obs_mask  [16];
    logic [3:0]  obs_bid;
    logic [1:0]  obs_bresp;
    logic        obs_hold_ok;
    logic        obs_aw_after;
    logic        obs_bv_after;
    int          obs_extra;
    int          obs_timeouts;
    logic        exp_we    [16];
    logic [9:0]  exp_addr  [16];
    logic [1:0]  exp_resp;

    axi_wr_slave #(.ADDR_BASE(BASE), .MEM_AW(MAW)) dut (
        .aclk(aclk), .arst(arst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
    );

    always #5 aclk = ~aclk;

    function automatic logic in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'h2000);
    endfunction

    // Expected memory writes and response, derived beat by beat from the burst rules.
    task automatic model_burst(input logic [31:0] addr, input int len, input int size,
                               input int burst, input int bad_wid_beat, input int wlast_beat);
        longint bytes, boundary, base;
        logic [31:0] a;
        logic dec, slv, sup, ovf;
        logic [1:0] err;
        bytes    = longint'(1) << size;
        dec      = !in_window(addr);
        slv      = (size > 3) || (burst == 3) ||
                   ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
        err      = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
        sup      = dec || slv;
        ovf      = 1'b0;
        boundary = bytes * (len + 1);
        base     = (longint'(addr) / boundary) * boundary;
        for (int k = 0; k <= len; k++) begin
            case (burst)
                1:       a = addr + 32'(k) * 32'(bytes);
                2:       a = 32'(base + ((longint'(addr) - base) + k * bytes) % boundary);
                default: a = addr;
            endcase
            if (!sup && !ovf && !in_window(a)) begin
                ovf = 1'b1;
                err = 2'b11;
            end
            exp_we[k]   = !sup && !ovf && (k != bad_wid_beat);
            exp_addr[k] = 10'((a - BASE) >> 3);
            if (((k == bad_wid_beat) || ((k == wlast_beat) != (k == len))) && (err != 2'b11))
                err = 2'b10;
        end
        exp_resp = err;
    endtask

    // Drives one burst through AW, W and B and records what the memory port and B channel did.
    task automatic drive_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input int size, input int burst, input int bad_wid_beat,
                               input int wlast_beat, input int max_gap, input int bdelay,
                               input int abort_beat);
        int n;
        obs_extra = 0; obs_timeouts = 0; obs_hold_ok = 1'b1;
        obs_aw_after = 1'b0; obs_bv_after = 1'b1;
        for (int k = 0; k < 16; k++) obs_we[k] = 1'b0;
        awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
        if (awready !== 1'b1) begin obs_timeouts++; awvalid = 1'b0; return; end
        @(negedge aclk);
        awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(negedge aclk);
                if (mem_we) obs_extra++;
            end
            beat_data[k] = {$urandom, $urandom};
            beat_strb[k] = 4'($urandom);
            wid = (k == bad_wid_beat) ? (id ^ 4'h9) : id;
            wdata = beat_data[k]; wstrb = beat_strb[k];
            wlast = (k == wlast_beat); wvalid = 1'b1;
            n = 0;
            while (wready !== 1'b1 && n < 20) begin
                @(negedge aclk);
                if (mem_we) obs_extra++;
                n++;
            end
            if (wready !== 1'b1) begin obs_timeouts++; wvalid = 1'b0; return; end
            if (k == abort_beat) arst = 1'b0;
            @(negedge aclk);
            obs_we[k] = mem_we; obs_addr[k] = mem_addr;
            obs_data[k] = mem_wdata; obs_mask[k] = mem_wmask;
            wvalid = 1'b0; wlast = 1'b0;
            if (k == abort_beat) return;
        end
        n = 0;
        while (bvalid !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
        if (bvalid !== 1'b1) begin obs_timeouts++; return; end
        obs_bid = bid; obs_bresp = bresp;
        if (awready !== 1'b0) obs_hold_ok = 1'b0;
        repeat (bdelay) begin
            @(negedge aclk);
            if (bvalid !== 1'b1 || bid !== obs_bid || bresp !== obs_bresp || awready !== 1'b0)
                obs_hold_ok = 1'b0;
            if (mem_we) obs_extra++;
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        obs_aw_after = awready; obs_bv_after = bvalid;
    endtask

    task automatic test_reset();
        arst = 1'b0;
        repeat (3) @(negedge aclk);
        n_checks++;
        if ({awready, wready, bvalid, mem_we, bid, bresp, mem_addr, mem_wdata, mem_wmask} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: awready=%0b wready=%0b bvalid=%0b mem_we=%0b bid=%0h bresp=%0h mem_addr=%0h required all zero",
                     awready, wready, bvalid, mem_we, bid, bresp, mem_addr);
        end
        arst = 1'b1;
        @(negedge aclk);
        n_checks++;
        if (awready !== 1'b1) begin n_fail++; $display("FAIL reset_release_awready: got %0b required 1", awready); end
    endtask

    task automatic test_incr();
        int ea [4] = '{8, 9, 10, 11};
        drive_burst(4'd5, BASE + 32'h40, 3, 3, 1, -1, 3, 0, 0, -1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_we[k] !== 1'b1 || obs_addr[k] !== 10'(ea[k]) || obs_data[k] !== beat_data[k] ||
                obs_mask[k] !== beat_strb[k]) begin
                n_fail++;
                $display("FAIL incr_beat%0d: we=%0b addr=%0d data=%h mask=%h required we=1 addr=%0d data=%h mask=%h",
                         k, obs_we[k], obs_addr[k], obs_data[k], obs_mask[k], ea[k], beat_data[k], beat_strb[k]);
            end
        end
        n_checks++;
        if (obs_bid !== 4'd5 || obs_bresp !== 2'b00 || obs_extra != 0 || obs_timeouts != 0) begin
            n_fail++;
            $display("FAIL incr_resp: bid=%0d bresp=%0b extra=%0d timeouts=%0d required 5 00 0 0",
                     obs_bid, obs_bresp, obs_extra, obs_timeouts);
        end
    endtask

    task automatic test_wrap();
        int ea [4] = '{3, 0, 1, 2};
        drive_burst(4'd2, BASE + 32'h18, 3, 3, 2, -1, 3, 1, 0, -1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_we[k] !== 1'b1 || obs_addr[k] !== 10'(ea[k])) begin
                n_fail++;
                $display("FAIL wrap_beat%0d: we=%0b addr=%0d required we=1 addr=%0d", k, obs_we[k], obs_addr[k], ea[k]);
            end
        end
        n_checks++;
        if (obs_bresp !== 2'b00 || obs_extra != 0 || obs_timeouts != 0) begin
            n_fail++;
            $display("FAIL wrap_resp: bresp=%0b extra=%0d timeouts=%0d required 00 0 0", obs_bresp, obs_extra, obs_timeouts);
        end
    endtask

    task automatic test_wlast_early();
        drive_burst(4'd7, BASE, 3, 3, 1, -1, 1, 1, 0, -1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_we[k] !== 1'b1 || obs_addr[k] !== 10'(k)) begin
                n_fail++;
                $display("FAIL wlast_early_beat%0d: we=%0b addr=%0d required we=1 addr=%0d", k, obs_we[k], obs_addr[k], k);
            end
        end
        n_checks++;
        if (obs_bresp !== 2'b10 || obs_timeouts != 0) begin
            n_fail++;
            $display("FAIL wlast_early_resp: bresp=%0b timeouts=%0d required 10 0", obs_bresp, obs_timeouts);
        end
    endtask

    task automatic test_decerr();
        drive_burst(4'd9, BASE + 32'h2000, 1, 3, 1, -1, 1, 1, 0, -1);
        n_checks++;
        if (obs_we[0] !== 1'b0 || obs_we[1] !== 1'b0 || obs_extra != 0) begin
            n_fail++;
            $display("FAIL decerr_no_write: we0=%0b we1=%0b extra=%0d required 0 0 0", obs_we[0], obs_we[1], obs_extra);
        end
        n_checks++;
        if (obs_bresp !== 2'b11 || obs_bid !== 4'd9 || obs_timeouts != 0) begin
            n_fail++;
            $display("FAIL decerr_resp: bresp=%0b bid=%0d timeouts=%0d required 11 9 0", obs_bresp, obs_bid, obs_timeouts);
        end
    endtask

    task automatic test_bready_stall();
        drive_burst(4'd12, BASE + 32'h100, 0, 3, 1, -1, 0, 0, 5, -1);
        n_checks++;
        if (obs_hold_ok !== 1'b1 || obs_bid !== 4'd12 || obs_bresp !== 2'b00 || obs_timeouts != 0) begin
            n_fail++;
            $display("FAIL stall_hold: hold_ok=%0b bid=%0d bresp=%0b timeouts=%0d required 1 12 00 0",
                     obs_hold_ok, obs_bid, obs_bresp, obs_timeouts);
        end
        n_checks++;
        if (obs_aw_after !== 1'b1 || obs_bv_after !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_after_b: awready=%0b bvalid=%0b required 1 0", obs_aw_after, obs_bv_after);
        end
    endtask

    task automatic test_reset_mid_burst();
        drive_burst(4'd4, BASE + 32'h80, 7, 3, 1, -1, 7, 0, 0, 2);
        n_checks++;
        if (obs_we[0] !== 1'b1 || obs_we[1] !== 1'b1 || obs_we[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_writes: we0=%0b we1=%0b we2=%0b required 1 1 0", obs_we[0], obs_we[1], obs_we[2]);
        end
        n_checks++;
        if ({awready, wready, bvalid, mem_we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_idle: awready=%0b wready=%0b bvalid=%0b mem_we=%0b required 0 0 0 0",
                     awready, wready, bvalid, mem_we);
        end
        arst = 1'b1;
        @(negedge aclk);
        n_checks++;
        if (awready !== 1'b1 || bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_release: awready=%0b bvalid=%0b required 1 0", awready, bvalid);
        end
        drive_burst(4'd3, BASE + 32'h100, 1, 3, 1, -1, 1, 1, 1, -1);
        n_checks++;
        if (obs_we[0] !== 1'b1 || obs_addr[0] !== 10'h20 || obs_we[1] !== 1'b1 || obs_addr[1] !== 10'h21 ||
            obs_bresp !== 2'b00 || obs_bid !== 4'd3 || obs_extra != 0) begin
            n_fail++;
            $display("FAIL abort_fresh_burst: addr0=%0h addr1=%0h bresp=%0b bid=%0d extra=%0d required 20 21 00 3 0",
                     obs_addr[0], obs_addr[1], obs_bresp, obs_bid, obs_extra);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int len, size, burst, bad, wl, mode;
        logic [3:0] id;
        for (int t = 0; t < 40; t++) begin
            id    = 4'($urandom);
            len   = $urandom_range(0, 15);
            size  = ($urandom_range(0, 7) == 0) ? 4 : $urandom_range(0, 3);
            burst = $urandom_range(0, 3);
            mode  = $urandom_range(0, 9);
            if (mode == 0)      addr = BASE - 32'(8 * $urandom_range(1, 4));
            else if (mode == 1) addr = BASE + 32'h2000 + 32'(8 * $urandom_range(0, 4));
            else if (mode < 4)  addr = BASE + 32'h2000 - 32'(8 * $urandom_range(1, 8));
            else                addr = BASE + 32'($urandom_range(0, 1023) << 3);
            bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
            wl  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : len;
            drive_burst(id, addr, len, size, burst, bad, wl, 2, $urandom_range(0, 3), -1);
            model_burst(addr, len, size, burst, bad, wl);
            for (int k = 0; k <= len; k++) begin
                n_checks++;
                if (obs_we[k] !== exp_we[k] ||
                    (exp_we[k] && (obs_addr[k] !== exp_addr[k] || obs_data[k] !== beat_data[k] ||
                                   obs_mask[k] !== beat_strb[k]))) begin
                    n_fail++;
                    $display("FAIL rand%0d_beat%0d: we=%0b addr=%0h data=%h mask=%h required we=%0b addr=%0h data=%h mask=%h",
                             t, k, obs_we[k], obs_addr[k], obs_data[k], obs_mask[k],
                             exp_we[k], exp_addr[k], beat_data[k], beat_strb[k]);
                end
            end
            n_checks++;
            if (obs_bresp !== exp_resp || obs_bid !== id || obs_extra != 0 || obs_timeouts != 0 ||
                obs_hold_ok !== 1'b1 || obs_aw_after !== 1'b1) begin
                n_fail++;
                $display("FAIL rand%0d_resp: bresp=%0b bid=%0h extra=%0d timeouts=%0d hold=%0b aw_after=%0b required %0b %0h 0 0 1 1",
                         t, obs_bresp, obs_bid, obs_extra, obs_timeouts, obs_hold_ok, obs_aw_after, exp_resp, id);
            end
        end
    endtask

    initial begin
        arst = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        test_reset();
        test_incr();
        test_wrap();
        test_wlast_early();
        test_decerr();
        test_bready_stall();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_wr_slave.md
Name: axi_wr_slave

Overview:
- AXI write-path slave that sits directly downstream of the environment's AXI interface: consumes the AW, W and B channels.
- Converts each accepted burst into a stream of single-beat writes on a simple word-addressed memory port.
- Returns one write response per burst.
- One burst in flight at a time; read channels are handled elsewhere.

Parameters:
ADDR_BASE, 32'h0000_0000, byte address of memory word 0
MEM_AW, 10, memory word-address width (memory = 2**MEM_AW 64-bit words)

Ports:
aclk  in  1  clock, all logic on rising edge
arst  in  1  synchronous active-low reset
awid  in  4  write address ID
awaddr  in  32  burst start byte address
awlen  in  4  beats minus one
awsize  in  3  log2 bytes per beat
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
awvalid  in  1  AW valid
awready  out  1  AW ready
wid  in  4  write data ID
wdata  in  64  write data
wstrb  in  4  lane enables; bit i covers wdata[16i+15:16i]
wlast  in  1  last beat marker
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  4  response ID
bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
bvalid  out  1  B valid
bready  in  1  B ready
mem_we  out  1  memory write strobe, one cycle per written beat
mem_addr  out  MEM_AW  memory word address
mem_wdata  out  64  memory write data
mem_wmask  out  4  16-bit lane mask (copy of wstrb)
- Lock, cache, prot, qos and region fields are not ports of this block.

Behaviour:
- Reset (arst=0 at a clock edge):
  - state=IDLE.
  - awready, wready, bvalid and mem_we are 0; bid, bresp, mem_addr, mem_wdata and mem_wmask are 0.
  - awready is gated low for as long as arst=0.
  - Reset mid-burst abandons the burst; no response is issued.
- FSM IDLE -> DATA -> RESP -> IDLE:
  - awready=1 only in IDLE; wready=1 only in DATA; bvalid=1 only in RESP. All three are decoded from the registered state.
- IDLE: AW handshake (awvalid&&awready) captures id, addr, len, size and burst; beat counter=0; err=OKAY; next state DATA.
- Capture-time checks:
  - awsize>3, awburst=11, or WRAP with awlen not in {1,3,7,15} -> err=SLVERR.
  - Start address outside [ADDR_BASE, ADDR_BASE+8*2**MEM_AW) -> err=DECERR.
  - DECERR takes precedence over SLVERR.
  - If err is set at capture, the burst is still fully accepted on W, but no mem_we is issued.
- DATA, each W handshake:
  - If err=OKAY and wid==captured id: mem_we=1 on the next cycle with mem_addr=(addr-ADDR_BASE)>>3 truncated to MEM_AW bits, mem_wdata=wdata, mem_wmask=wstrb. Latency from handshake to write is exactly 1 cycle.
  - wid mismatch: beat is not written; err=SLVERR (sticky).
  - wlast=1 with counter<len, or wlast=0 with counter==len: err=SLVERR (sticky). The beat is still written if no other error applies.
  - Burst length is always governed by awlen. When counter==len, the state moves to RESP; otherwise the counter increments.
- Address update per beat, with B = 1<<size:
  - FIXED: unchanged.
  - INCR: addr+B, 32-bit wrap-around.
  - WRAP: boundary = B*(len+1); the address wraps to the aligned base when it reaches base+boundary.
  - Mid-burst range overflow on INCR: later beats are suppressed and err=DECERR.
- RESP: bvalid=1, bid=captured id, bresp=err. Both are held stable until bready. On the B handshake the state returns to IDLE, and the next AW is accepted no earlier than the following cycle.
- mem_we is a single-cycle pulse. Back-to-back W beats produce back-to-back mem_we.

Decomposition:
- Shared package axi_pkg holds:
  - burst enum (FIXED/INCR/WRAP/RSVD);
  - resp constants (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11);
  - width constants ID_W=4, ADDR_W=32, DATA_W=64, STRB_W=4, LEN_W=4.
- One sub-module, axi_burst_addr_gen: combinational next-address from (addr, size, len, burst). It is reusable by the future read slave.

Test Plan:
- INCR len=3 size=3 addr=ADDR_BASE+0x40, id=5, wlast on beat 3 -> mem_addr 8,9,10,11 with mem_we on 4 consecutive cycles; bid=5, bresp=00.
- WRAP len=3 size=3 addr=ADDR_BASE+0x18 -> mem_addr 3,0,1,2; bresp=00.
- wlast asserted on beat 1 of a len=3 INCR -> 4 beats accepted and written; bresp=10.
- awaddr=ADDR_BASE+8*2**MEM_AW, len=1 -> 2 beats accepted, no mem_we; bresp=11.
- bready held low for 5 cycles in RESP -> bvalid, bid and bresp stable, awready=0 throughout; awready=1 one cycle after the B handshake.
- arst=0 asserted on beat 2 of a len=7 burst -> the next cycle shows IDLE outputs, bvalid=0; a fresh burst after reset completes with OKAY.
